// File: rtl/pad_pkg.sv
// Shared types and constants for the NES pad reader.
package pad_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StLow,
    StHigh,
    StDone
  } pad_state_e;

  // Bit positions within the button byte; serial order from the 4021 matches.
  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  // Data line stuck low reads back as every button pressed: treat as no pad.
  localparam logic [7:0] PAD_ABSENT = 8'hFF;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, with a configurable reset value.
module sync_2ff #(
  parameter int unsigned        Width    = 1,
  parameter logic [Width-1:0]   ResetVal = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  // Two-stage capture; reset drives both stages to the idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/nes_pad_reader.sv
// Polls a 4021-based NES pad once per i_poll strobe and presents registered button levels.
module nes_pad_reader
  import pad_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 150
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_poll,
  input  logic       i_pad_data,
  output logic       o_pad_latch,
  output logic       o_pad_clk,
  output logic [7:0] o_buttons,
  output logic       o_up,
  output logic       o_down,
  output logic       o_left,
  output logic       o_right,
  output logic       o_pause,
  output logic       o_restart,
  output logic       o_present,
  output logic       o_valid
);

  localparam int unsigned    CntW      = $clog2(2 * HALF_PERIOD);
  localparam logic [CntW-1:0] HalfLast  = CntW'(HALF_PERIOD - 1);
  localparam logic [CntW-1:0] LatchLast = CntW'(2 * HALF_PERIOD - 1);

  pad_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      buttons_q, buttons_d;
  logic            present_q, present_d;
  logic            valid_q, valid_d;
  logic            latch_q, latch_d;
  logic            pclk_q, pclk_d;
  logic            sync_data;

  sync_2ff #(
    .Width    (1),
    .ResetVal (1'b1)
  ) u_sync_data (
    .clk (clk),
    .rst (rst),
    .d_i (i_pad_data),
    .q_o (sync_data)
  );

  // Next-state, shift capture and result update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    buttons_d = buttons_q;
    present_d = present_q;
    valid_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_poll) begin
          state_d = StLatch;
          cnt_d   = '0;
          idx_d   = '0;
          shift_d = '0;
        end
      end
      StLatch: begin
        if (cnt_q == LatchLast) begin
          state_d = StLow;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StLow: begin
        if (cnt_q == HalfLast) begin
          cnt_d          = '0;
          // Sample at the end of the low phase so the pad has settled.
          shift_d[idx_q] = ~sync_data;
          state_d        = (idx_q == 3'd7) ? StDone : StHigh;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHigh: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          idx_d   = idx_q + 3'd1;
          state_d = StLow;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        valid_d = 1'b1;
        if (shift_q == PAD_ABSENT) begin
          buttons_d = '0;
          present_d = 1'b0;
        end else begin
          buttons_d = shift_q;
          present_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Pins follow the state being entered so they are registered alongside it.
    latch_d = (state_d == StLatch);
    pclk_d  = (state_d == StHigh);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      buttons_q <= '0;
      present_q <= 1'b0;
      valid_q   <= 1'b0;
      latch_q   <= 1'b0;
      pclk_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      buttons_q <= buttons_d;
      present_q <= present_d;
      valid_q   <= valid_d;
      latch_q   <= latch_d;
      pclk_q    <= pclk_d;
    end
  end

  assign o_pad_latch = latch_q;
  assign o_pad_clk   = pclk_q;
  assign o_buttons   = buttons_q;
  assign o_present   = present_q;
  assign o_valid     = valid_q;
  assign o_up        = buttons_q[BTN_UP];
  assign o_down      = buttons_q[BTN_DOWN];
  assign o_left      = buttons_q[BTN_LEFT];
  assign o_right     = buttons_q[BTN_RIGHT];
  assign o_pause     = buttons_q[BTN_START];
  assign o_restart   = buttons_q[BTN_SELECT];

endmodule

// File: tb/tb_nes_pad_reader.sv
// Scoreboard bench for nes_pad_reader with a behavioural 4021 pad model.
module tb_nes_pad_reader;

  localparam int unsigned H   = 4;
  localparam int          LAT = 17 * H + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_poll;
  logic       i_pad_data;
  logic       o_pad_latch, o_pad_clk;
  logic [7:0] o_buttons;
  logic       o_up, o_down, o_left, o_right, o_pause, o_restart, o_present, o_valid;

  nes_pad_reader #(
    .HALF_PERIOD (H)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_poll      (i_poll),
    .i_pad_data  (i_pad_data),
    .o_pad_latch (o_pad_latch),
    .o_pad_clk   (o_pad_clk),
    .o_buttons   (o_buttons),
    .o_up        (o_up),
    .o_down      (o_down),
    .o_left      (o_left),
    .o_right     (o_right),
    .o_pause     (o_pause),
    .o_restart   (o_restart),
    .o_present   (o_present),
    .o_valid     (o_valid)
  );

  always #5 clk = ~clk;

  // Behavioural 4021: parallel load while latch high, shift on clk rise.
  logic [7:0] pad_byte = 8'h00;  // 1 = pressed
  logic       absent   = 1'b0;
  logic [7:0] pad_sr   = 8'h00;
  always @(posedge o_pad_latch or posedge o_pad_clk) begin
    if (o_pad_latch) pad_sr = pad_byte;
    else             pad_sr = pad_sr >> 1;
  end
  assign i_pad_data = absent ? 1'b0 : ~pad_sr[0];

  typedef struct {
    int         due;
    logic [7:0] btn;
    logic       pres;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc        = 0;
  int         busy_until = -1;
  int         checks     = 0;
  int         failures   = 0;
  logic [7:0] held_btn   = 8'h00;
  logic       held_pres  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=0x%0h required=0x%0h", name, cyc, act, req);
    end
  endtask

  // Reference: what a read of the current pad should report.
  function automatic exp_t predict(input int due);
    exp_t       e;
    logic [7:0] seen;
    seen   = absent ? 8'hFF : pad_byte;
    e.due  = due;
    e.btn  = (seen == 8'hFF) ? 8'h00 : seen;
    e.pres = (seen != 8'hFF);
    return e;
  endfunction

  // Drive i_poll for the edge numbered e; the model decides whether it is accepted.
  task automatic poll_at(input int e);
    while (cyc + 1 < e) @(negedge clk);
    i_poll = 1'b1;
    if (!rst && (cyc + 1) > busy_until) begin
      exp_q.push_back(predict(cyc + 1 + LAT));
      busy_until = cyc + 1 + LAT;
    end
    @(negedge clk);
    i_poll = 1'b0;
  endtask

  task automatic poll_now(output int e);
    e = cyc + 1;
    poll_at(e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  int   lat_cnt  = 0;
  int   rise_cnt = 0;
  logic prev_pclk = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
        check("reset_outputs", {o_pad_latch, o_pad_clk, o_valid, o_present, o_buttons}, 0);
        lat_cnt   = 0;
        rise_cnt  = 0;
        prev_pclk = 1'b0;
        held_btn  = 8'h00;
        held_pres = 1'b0;
      end else begin
        logic expect_valid;
        if (o_pad_latch) lat_cnt++;
        if (o_pad_clk && !prev_pclk) rise_cnt++;
        prev_pclk    = o_pad_clk;
        expect_valid = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        check("o_valid", o_valid, expect_valid);
        if (expect_valid) begin
          exp_t e;
          e = exp_q.pop_front();
          check("o_buttons", o_buttons, e.btn);
          check("o_present", o_present, e.pres);
          check("aliases", {o_right, o_left, o_down, o_up, o_pause, o_restart},
                {e.btn[7:4], e.btn[3], e.btn[2]});
          check("latch_cycles", lat_cnt, 2 * H);
          check("clk_rises", rise_cnt, 7);
          lat_cnt   = 0;
          rise_cnt  = 0;
          held_btn  = e.btn;
          held_pres = e.pres;
        end else if (cyc > busy_until) begin
          check("idle_pins", {o_pad_latch, o_pad_clk}, 2'b00);
          check("held_outputs", {o_present, o_buttons}, {held_pres, held_btn});
        end
      end
    end
  end

  initial begin
    int t;
    // Reset with i_poll held high.
    rst    = 1'b1;
    i_poll = 1'b1;
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    i_poll = 1'b0;
    repeat (100) @(negedge clk);

    // Up only, then Start+Select+Left, then nothing pressed.
    pad_byte = 8'h10;
    poll_now(t);
    wait_idle();
    pad_byte = 8'h4C;
    poll_now(t);
    wait_idle();
    pad_byte = 8'h00;
    poll_now(t);
    wait_idle();

    // Absent pad.
    absent = 1'b1;
    poll_now(t);
    wait_idle();
    absent = 1'b0;

    // Polls while busy are ignored.
    pad_byte = 8'h81;
    poll_now(t);
    poll_at(t + 10);
    poll_at(t + 40);
    wait_idle();

    // Mid-read reset aborts, then a fresh read completes.
    pad_byte = 8'h22;
    poll_now(t);
    while (cyc + 1 < t + 30) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    busy_until = -1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    poll_now(t);
    wait_idle();

    // Randomized reads with occasional busy polls and absent pads.
    for (int n = 0; n < 20; n++) begin
      pad_byte = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      absent   = ($urandom_range(0, 7) == 0);
      poll_now(t);
      if ($urandom_range(0, 1) == 1) poll_at(t + int'($urandom_range(2, LAT - 1)));
      wait_idle();
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    absent = 1'b0;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
